sensor_status_encoder: RTL and testbench
========================================

SENSOR_STATUS_ENCODER -- requirements
Module: sensor_status_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized samples required to accept a level change (legal range 1..65535).
REQ-002 clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ir_left  input  1  left line sensor, asynchronous, 1 = line detected.
REQ-005 ir_center  input  1  center line sensor, asynchronous, 1 = line detected.
REQ-006 ir_right  input  1  right line sensor, asynchronous, 1 = line detected.
REQ-007 oc_in  input  1  overcurrent comparator, asynchronous, 1 = overcurrent.
REQ-008 oc_clear  input  1  synchronous one-cycle pulse that acknowledges a latched overcurrent.
REQ-009 number  output  4  one-hot status for the seven-segment driver: [3]=L, [2]=C, [1]=R, [0]=O, 0000 = nothing; registered.
REQ-010 changed  output  1  one-cycle pulse, asserted in the cycle after number takes a new value.

Function
REQ-011 Each of the 4 sensor inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL have a debounced level plus a saturating counter sized for DEBOUNCE_CYCLES.
REQ-013 Debounce rule: the counter clears whenever the synchronized level equals the debounced level, and increments otherwise.
REQ-014 When the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL take the synchronized level and the counter SHALL clear in that same cycle.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced level.
REQ-016 FSM states: IDLE (no line detected), TRACK (at least one line sensor detected), OC (overcurrent).
REQ-017 In IDLE, any debounced line sensor going to 1 -> TRACK.
REQ-018 In TRACK, all debounced line sensors at 0 -> IDLE.
REQ-019 In any state, debounced oc = 1 -> OC; this has priority over every other transition.
REQ-020 Leaving OC SHALL go to TRACK if any line sensor is debounced high, otherwise to IDLE; the exit condition is set by REQ-032/REQ-033.
REQ-021 number encoding: IDLE -> 0000; OC -> 0001.
REQ-022 number encoding in TRACK, by priority: C -> 0100, else L -> 1000, else R -> 0010; L and R both high with C low -> 0100.
REQ-023 number SHALL always be one-hot or 0000; no other value is legal.
REQ-024 Latency: a clean input step sampled at edge k SHALL appear on number at edge k+DEBOUNCE_CYCLES+3 (2 sync + debounce + output register).
REQ-025 changed SHALL be 1 for exactly one cycle per change of number, and 0 otherwise.
REQ-026 oc_clear while not in OC SHALL be ignored; it SHALL NOT be stored for later use.

Reset
REQ-027 While rst_n = 0 at a clock edge: synchronizer flops, debounced levels and counters SHALL be cleared to 0.
REQ-028 While rst_n = 0 at a clock edge: FSM = IDLE, number = 0000, changed = 0.
REQ-029 Reset asserted mid-operation (including in OC or during a debounce count) SHALL discard all history; after release, sensors are re-qualified from zero.
REQ-030 The first changed pulse after reset SHALL occur only when number leaves 0000.

Configuration
REQ-031 Macro SENSOR_OC_LATCH_EN selects overcurrent latching behaviour.
REQ-032 With SENSOR_OC_LATCH_EN defined: OC SHALL be exited only on the cycle after oc_clear = 1 while debounced oc = 0. If oc_clear arrives while debounced oc = 1, the FSM SHALL stay in OC and the clear is lost.
REQ-033 With SENSOR_OC_LATCH_EN undefined: OC SHALL be exited on the cycle after debounced oc = 0. oc_clear SHALL be unused and have no effect.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-034 Reset -> hold ir_center = 1 from edge 0 -> number = 0000 through edge 6, number = 0100 at edge 7, changed = 1 for one cycle.
REQ-035 Reset -> ir_left pulse of 3 cycles -> number remains 0000 and changed never asserts.
REQ-036 ir_left = ir_right = 1, ir_center = 0 -> number = 0100; then drop ir_right -> number = 1000 after 7 cycles.
REQ-037 SENSOR_OC_LATCH_EN defined, number = 0010 -> oc_in = 1 -> number = 0001.
REQ-038 Continuing REQ-037: oc_in = 0, then oc_clear -> number = 0010 one cycle after the clear. An oc_clear issued while debounced oc = 1 leaves number = 0001.
REQ-039 In OC with number = 0001 -> pulse rst_n = 0 for 1 cycle -> number = 0000 next edge, and FSM in IDLE with inputs low.

Source files
------------

// File: rtl/sensor_status_encoder.sv
// sensor_status_encoder: synchronizes, debounces and prioritises three
// line sensors and an overcurrent comparator into a one-hot status code.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   ir_left    left line sensor (async, 1 = line)
//   ir_center  center line sensor (async, 1 = line)
//   ir_right   right line sensor (async, 1 = line)
//   oc_in      overcurrent comparator (async, 1 = overcurrent)
//   oc_clear   one-cycle acknowledge of a latched overcurrent
//   number     one-hot status {L,C,R,O}, 0000 = nothing, registered
//   changed    one-cycle pulse while number shows a new value
//
// Parameter
//   DEBOUNCE_CYCLES  stable samples needed to accept a level (1..65535)
//
// Build option
//   SENSOR_OC_LATCH_EN  when defined, overcurrent stays latched until
//                       oc_clear arrives with the debounced oc low;
//                       when undefined, OC follows debounced oc and
//                       oc_clear is ignored.

module sensor_status_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_left,
  input  logic       ir_center,
  input  logic       ir_right,
  input  logic       oc_in,
  input  logic       oc_clear,
  output logic [3:0] number,
  output logic       changed
);

  // Channel positions inside the 4-bit sensor vectors.
  localparam int CH_L = 0;
  localparam int CH_C = 1;
  localparam int CH_R = 2;
  localparam int CH_O = 3;

  // The counter has to be able to hold DEBOUNCE_CYCLES itself.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [3:0] NUM_NONE = 4'b0000;
  localparam logic [3:0] NUM_L    = 4'b1000;
  localparam logic [3:0] NUM_C    = 4'b0100;
  localparam logic [3:0] NUM_R    = 4'b0010;
  localparam logic [3:0] NUM_O    = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_OC    = 2'd2
  } state_t;

  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_deb;

  logic       w_l;
  logic       w_c;
  logic       w_r;
  logic       w_oc;
  logic       w_any_line;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] w_track_code;
  logic [3:0] w_num_nxt;
  logic [3:0] r_number;
  logic       r_changed;

  assign w_raw = {oc_in, ir_right, ir_center, ir_left};

  // ------------------------------------------------------------
  // Two-flop synchronizers for all four asynchronous inputs.
  // ------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ------------------------------------------------------------
  // Per-channel debounce. The counter tracks how long the
  // synchronized level has disagreed with the accepted level.
  // Once it has reached CNT_MAX, the next edge adopts the
  // synchronized level; that extra edge is part of the
  // DEBOUNCE_CYCLES+3 end-to-end latency.
  // ------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic [CW-1:0] r_cnt;
    logic          r_lvl;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_cnt == CNT_MAX) begin
        r_lvl <= r_sync2[g];
        r_cnt <= '0;
      end else if (r_sync2[g] == r_lvl) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign w_deb[g] = r_lvl;
  end

  assign w_l        = w_deb[CH_L];
  assign w_c        = w_deb[CH_C];
  assign w_r        = w_deb[CH_R];
  assign w_oc       = w_deb[CH_O];
  assign w_any_line = w_l | w_c | w_r;

  // ------------------------------------------------------------
  // Line priority: center first, then left, then right. Left and
  // right together without center means the robot straddles the
  // line, which is reported as center.
  // ------------------------------------------------------------
  always_comb begin
    w_track_code = NUM_NONE;
    unique case (1'b1)
      w_c:                 w_track_code = NUM_C;
      (!w_c & w_l & w_r):  w_track_code = NUM_C;
      (!w_c & w_l & !w_r): w_track_code = NUM_L;
      (!w_c & !w_l & w_r): w_track_code = NUM_R;
      default:             w_track_code = NUM_NONE;
    endcase
  end

  // ------------------------------------------------------------
  // Next-state logic. Debounced overcurrent always wins.
  // ------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_oc) begin
      w_state_nxt = S_OC;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any_line) w_state_nxt = S_TRACK;
        end
        S_TRACK: begin
          if (!w_any_line) w_state_nxt = S_IDLE;
        end
        S_OC: begin
`ifdef SENSOR_OC_LATCH_EN
          // Only an acknowledge seen with oc already low releases
          // the latch; an early acknowledge is simply dropped.
          if (oc_clear)
            w_state_nxt = w_any_line ? S_TRACK : S_IDLE;
`else
          w_state_nxt = w_any_line ? S_TRACK : S_IDLE;
`endif
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifndef SENSOR_OC_LATCH_EN
  // The acknowledge has no meaning without the latch.
  logic w_unused_oc_clear;
  assign w_unused_oc_clear = oc_clear;
`endif

  always_comb begin
    w_num_nxt = NUM_NONE;
    unique case (w_state_nxt)
      S_IDLE:  w_num_nxt = NUM_NONE;
      S_TRACK: w_num_nxt = w_track_code;
      S_OC:    w_num_nxt = NUM_O;
      default: w_num_nxt = NUM_NONE;
    endcase
  end

  // ------------------------------------------------------------
  // State and registered outputs. changed is produced on the
  // same edge that loads a different number, so it is high for
  // exactly the first cycle the new value is visible.
  // ------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_number  <= NUM_NONE;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_number  <= w_num_nxt;
      r_changed <= (w_num_nxt != r_number);
    end
  end

  assign number  = r_number;
  assign changed = r_changed;

endmodule

// File: tb/tb_sensor_status_encoder.sv
// Testbench for sensor_status_encoder (DEBOUNCE_CYCLES = 4).
// Directed scenarios plus randomized stimulus against a window model.
`timescale 1ns/1ps

module tb_sensor_status_encoder;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic       ir_left;
  logic       ir_center;
  logic       ir_right;
  logic       oc_in;
  logic       oc_clear;
  logic [3:0] number;
  logic       changed;

  int total;
  int bad;

  sensor_status_encoder #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_left  (ir_left),
    .ir_center(ir_center),
    .ir_right (ir_right),
    .oc_in    (oc_in),
    .oc_clear (oc_clear),
    .number   (number),
    .changed  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. A level is accepted once the last D+1
  // synchronized samples (raw input delayed by two edges) all
  // agree on a value different from the accepted one.
  // Bit order in the vectors: {oc, right, center, left}.
  logic [3:0] m_h [0:D+1];
  logic [3:0] m_deb;
  int         m_state;
  logic [3:0] m_num;
  logic       m_chg;

  task automatic model_edge();
    logic [3:0] raw;
    logic [3:0] nn;
    int         ns;
    bit         any;
    bit         agree;
    raw = {oc_in, ir_right, ir_center, ir_left};
    if (!rst_n) begin
      for (int j = 0; j <= D + 1; j++) m_h[j] = 4'b0;
      m_deb   = 4'b0;
      m_state = 0;
      m_num   = 4'b0;
      m_chg   = 1'b0;
    end else begin
      any = m_deb[0] | m_deb[1] | m_deb[2];
      if (m_deb[3]) ns = 2;
      else if (m_state == 2) begin
`ifdef SENSOR_OC_LATCH_EN
        ns = oc_clear ? (any ? 1 : 0) : 2;
`else
        ns = any ? 1 : 0;
`endif
      end else ns = any ? 1 : 0;
      if (ns == 2) nn = 4'b0001;
      else if (ns == 0) nn = 4'b0000;
      else if (m_deb[1] || (m_deb[0] && m_deb[2])) nn = 4'b0100;
      else if (m_deb[0]) nn = 4'b1000;
      else nn = 4'b0010;
      m_chg   = (nn != m_num);
      m_num   = nn;
      m_state = ns;
      for (int ch = 0; ch < 4; ch++) begin
        agree = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (m_h[j][ch] != m_h[1][ch]) agree = 1'b0;
        if (agree) m_deb[ch] = m_h[1][ch];
      end
      for (int j = D + 1; j >= 1; j--) m_h[j] = m_h[j-1];
      m_h[0] = raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic l, input logic c,
                        input logic r, input logic o);
    ir_left   = l;
    ir_center = c;
    ir_right  = r;
    oc_in     = o;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    oc_clear = 1'b0;
    set_in(0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    oc_clear = 1'b0;
    set_in(1, 1, 1, 1);
    tick();
    tick();
    total++;
    if (number !== 4'b0000) begin
      bad++;
      $display("FAIL reset_number: got %b want 0000", number);
    end
    total++;
    if (changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_changed: got %b want 0", changed);
    end
    set_in(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_center_latency();
    logic [3:0] exp;
    do_reset();
    ir_center = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      exp = (i >= 7) ? 4'b0100 : 4'b0000;
      total++;
      if (number !== exp) begin
        bad++;
        $display("FAIL center_latency edge%0d: got %b want %b",
                 i, number, exp);
      end
      total++;
      if (changed !== (i == 7)) begin
        bad++;
        $display("FAIL center_changed edge%0d: got %b want %b",
                 i, changed, (i == 7));
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ir_left = (i < 3);
      tick();
      total++;
      if (number !== 4'b0000 || changed !== 1'b0) begin
        bad++;
        $display("FAIL glitch edge%0d: got %b/%b want 0000/0",
                 i, number, changed);
      end
    end
  endtask

  task automatic test_lr_priority();
    logic [3:0] exp;
    do_reset();
    set_in(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (number !== 4'b0100) begin
      bad++;
      $display("FAIL lr_both: got %b want 0100", number);
    end
    ir_right = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      tick();
      exp = (i >= 7) ? 4'b1000 : 4'b0100;
      total++;
      if (number !== exp || changed !== (i == 7)) begin
        bad++;
        $display("FAIL lr_drop edge%0d: got %b/%b want %b/%b",
                 i, number, changed, exp, (i == 7));
      end
    end
  endtask

  task automatic test_overcurrent();
    logic [3:0] exp;
    do_reset();
    ir_right = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (number !== 4'b0010) begin
      bad++;
      $display("FAIL oc_pre_right: got %b want 0010", number);
    end
    oc_in = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      exp = (i >= 7) ? 4'b0001 : 4'b0010;
      total++;
      if (number !== exp) begin
        bad++;
        $display("FAIL oc_enter edge%0d: got %b want %b",
                 i, number, exp);
      end
    end
    oc_clear = 1'b1;
    tick();
    oc_clear = 1'b0;
    tick();
    total++;
    if (number !== 4'b0001) begin
      bad++;
      $display("FAIL oc_early_clear: got %b want 0001", number);
    end
    oc_in = 1'b0;
`ifdef SENSOR_OC_LATCH_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (number !== 4'b0001) begin
        bad++;
        $display("FAIL oc_latched edge%0d: got %b want 0001",
                 i, number);
      end
    end
    oc_clear = 1'b1;
    tick();
    oc_clear = 1'b0;
    total++;
    if (number !== 4'b0010 || changed !== 1'b1) begin
      bad++;
      $display("FAIL oc_release: got %b/%b want 0010/1",
               number, changed);
    end
    tick();
    total++;
    if (number !== 4'b0010 || changed !== 1'b0) begin
      bad++;
      $display("FAIL oc_after_release: got %b/%b want 0010/0",
               number, changed);
    end
`else
    for (int i = 0; i <= 8; i++) begin
      tick();
      exp = (i >= 7) ? 4'b0010 : 4'b0001;
      total++;
      if (number !== exp || changed !== (i == 7)) begin
        bad++;
        $display("FAIL oc_exit edge%0d: got %b/%b want %b/%b",
                 i, number, changed, exp, (i == 7));
      end
    end
`endif
  endtask

  task automatic test_reset_in_oc();
    do_reset();
    oc_in = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    total++;
    if (number !== 4'b0001) begin
      bad++;
      $display("FAIL rst_oc_pre: got %b want 0001", number);
    end
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    total++;
    if (number !== 4'b0000 || changed !== 1'b0) begin
      bad++;
      $display("FAIL rst_oc_now: got %b/%b want 0000/0",
               number, changed);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (number !== 4'b0000 || changed !== 1'b0) begin
        bad++;
        $display("FAIL rst_oc_idle edge%0d: got %b/%b want 0000/0",
                 i, number, changed);
      end
    end
  endtask

  task automatic test_random();
    int         hold [4];
    logic [3:0] rv;
    rv = 4'b0;
    for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          rv[ch]   = 1'($urandom_range(0, 1));
          hold[ch] = (ch == 3) ? int'($urandom_range(1, 30))
                               : int'($urandom_range(1, 10));
        end
        hold[ch]--;
      end
      set_in(rv[0], rv[1], rv[2], rv[3]);
      oc_clear = ($urandom_range(0, 5) == 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      tick();
      total++;
      if (number !== m_num || changed !== m_chg) begin
        bad++;
        $display("FAIL random cyc%0d: got %b/%b want %b/%b",
                 n, number, changed, m_num, m_chg);
      end
      total++;
      if (!(number inside {4'b0000, 4'b0001, 4'b0010,
                           4'b0100, 4'b1000})) begin
        bad++;
        $display("FAIL onehot cyc%0d: got %b", n, number);
      end
    end
    rst_n    = 1'b1;
    oc_clear = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    oc_clear = 1'b0;
    set_in(0, 0, 0, 0);
    test_reset();
    test_center_latency();
    test_glitch();
    test_lr_priority();
    test_overcurrent();
    test_reset_in_oc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
